// File: rtl/bpd_pkg.sv
// Shared types for the branch-predictor table update arbiter.
// Holds the default index width, FSM state encoding and grant-source enum.
package bpd_pkg;

  localparam int IDX_W = 12;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_INIT,
    GNT_RD,
    GNT_UP,
    GNT_CH
  } gnt_e;

  // Last value of the init sweep counter for a table of 2^idx_w entries.
  function automatic int unsigned init_last(input int idx_w);
    return (32'd1 << idx_w) - 32'd1;
  endfunction

endpackage

// File: rtl/bpd_upd_arb_if.sv
// Request/update/table bus of bpd_upd_arb.
// The slave modport is the arbiter side; the master modport drives requests.
interface bpd_upd_arb_if #(
  parameter int IDX_W = bpd_pkg::IDX_W
);

  logic             rd_req_i;
  logic [IDX_W-1:0] rd_idx_i;
  logic             rd_gnt_o;
  logic             up_val_i;
  logic [IDX_W-1:0] up_idx_i;
  logic             up_dir_i;
  logic             ch_val_i;
  logic [IDX_W-1:0] ch_idx_i;
  logic             ch_dir_i;
  logic             reinit_i;
  logic             tbl_en_o;
  logic             tbl_we_o;
  logic [IDX_W-1:0] tbl_idx_o;
  logic             tbl_wdir_o;
  logic             tbl_init_o;
  logic             busy_o;
  logic             drop_o;

  modport slave (
    input  rd_req_i, rd_idx_i, up_val_i, up_idx_i, up_dir_i,
    input  ch_val_i, ch_idx_i, ch_dir_i, reinit_i,
    output rd_gnt_o, tbl_en_o, tbl_we_o, tbl_idx_o, tbl_wdir_o,
    output tbl_init_o, busy_o, drop_o
  );

  modport master (
    output rd_req_i, rd_idx_i, up_val_i, up_idx_i, up_dir_i,
    output ch_val_i, ch_idx_i, ch_dir_i, reinit_i,
    input  rd_gnt_o, tbl_en_o, tbl_we_o, tbl_idx_o, tbl_wdir_o,
    input  tbl_init_o, busy_o, drop_o
  );

endinterface

// File: rtl/bpd_upd_fifo.sv
// Retire-update FIFO: in-order {dir, idx} entries, power-of-two depth.
// Push and pop in the same cycle are both honoured, so a full FIFO may push while popping.
module bpd_upd_fifo #(
  parameter int IDX_W  = bpd_pkg::IDX_W,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [IDX_W-1:0] i_push_idx,
  input  logic             i_push_dir,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [IDX_W-1:0] o_head_idx,
  output logic             o_head_dir
);
  import bpd_pkg::*;

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] DEPTH = (PW + 1)'(QDEPTH);

  logic [IDX_W:0] r_mem [QDEPTH];
  logic [PW-1:0]  r_wp;
  logic [PW-1:0]  r_rp;
  logic [PW:0]    r_occ;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wp] <= {i_push_dir, i_push_idx};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (i_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (i_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (i_push && !i_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (i_pop && !i_push) begin
        r_occ <= r_occ - 1'b1;
      end
    end
  end

  assign o_full     = (r_occ == DEPTH);
  assign o_empty    = (r_occ == '0);
  assign o_head_idx = r_mem[r_rp][IDX_W-1:0];
  assign o_head_dir = r_mem[r_rp][IDX_W];

endmodule

// File: rtl/bpd_upd_arb.sv
// Single-port predictor table arbiter. ST_INIT sweeps every entry to weakly-taken,
// ST_RUN grants one of queued update / read / choice update per cycle with zero-cycle grant.
module bpd_upd_arb #(
  parameter int IDX_W      = bpd_pkg::IDX_W,
  parameter int QDEPTH     = 4,
  parameter int STARVE_LIM = 8
) (
  input logic          clock,
  input logic          reset,
  bpd_upd_arb_if.slave bus
);
  import bpd_pkg::*;

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0]    LIM      = SW'(STARVE_LIM);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(init_last(IDX_W));

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic [SW-1:0]    r_starve;
  logic [SW-1:0]    w_starve_nxt;

  gnt_e             w_gnt;
  logic             w_full;
  logic             w_empty;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_head_dir;
  logic             w_up_pri;
  logic             w_push;
  logic             w_pop;
  logic             w_en;
  logic             w_we;
  logic             w_ini;
  logic             w_rgnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_dir;
  logic             w_drop;

  bpd_upd_fifo #(
    .IDX_W  (IDX_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk        (clock),
    .rst        (reset),
    .i_push     (w_push),
    .i_push_idx (bus.up_idx_i),
    .i_push_dir (bus.up_dir_i),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_idx (w_head_idx),
    .o_head_dir (w_head_dir)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_INIT;
      r_cnt    <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.reinit_i) begin
      w_state_nxt = ST_INIT;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_INIT) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) begin
        w_state_nxt = ST_RUN;
      end
    end
  end

  // Starvation age of the FIFO head; it keeps ageing during the sweep too.
  always_comb begin
    if (w_pop || w_empty) begin
      w_starve_nxt = '0;
    end else if (r_starve == LIM) begin
      w_starve_nxt = LIM;
    end else begin
      w_starve_nxt = r_starve + 1'b1;
    end
  end

  assign w_up_pri = !w_empty && (w_full || (r_starve == LIM));

  always_comb begin
    w_gnt = GNT_NONE;
    if (r_state == ST_INIT) begin
      w_gnt = GNT_INIT;
    end else if (w_up_pri) begin
      w_gnt = GNT_UP;
    end else if (bus.rd_req_i) begin
      w_gnt = GNT_RD;
    end else if (!w_empty) begin
      w_gnt = GNT_UP;
    end else if (bus.ch_val_i) begin
      w_gnt = GNT_CH;
    end

    w_en   = 1'b0;
    w_we   = 1'b0;
    w_ini  = 1'b0;
    w_rgnt = 1'b0;
    w_idx  = '0;
    w_dir  = 1'b0;
    w_pop  = 1'b0;
    unique case (w_gnt)
      GNT_INIT: begin
        w_en  = 1'b1;
        w_we  = 1'b1;
        w_ini = 1'b1;
        w_idx = r_cnt;
      end
      GNT_RD: begin
        w_en   = 1'b1;
        w_rgnt = 1'b1;
        w_idx  = bus.rd_idx_i;
      end
      GNT_UP: begin
        w_en  = 1'b1;
        w_we  = 1'b1;
        w_idx = w_head_idx;
        w_dir = w_head_dir;
        w_pop = 1'b1;
      end
      GNT_CH: begin
        w_en  = 1'b1;
        w_we  = 1'b1;
        w_idx = bus.ch_idx_i;
        w_dir = bus.ch_dir_i;
      end
      default: ;
    endcase
  end

  // A full FIFO can only push when its head is leaving this same cycle.
  assign w_push = bus.up_val_i && (!w_full || w_pop);
  assign w_drop = (bus.ch_val_i && (w_gnt != GNT_CH)) || (bus.up_val_i && !w_push);

  assign bus.tbl_en_o   = w_en && !reset;
  assign bus.tbl_we_o   = w_we && !reset;
  assign bus.tbl_init_o = w_ini && !reset;
  assign bus.rd_gnt_o   = w_rgnt && !reset;
  assign bus.drop_o     = w_drop && !reset;
  assign bus.tbl_idx_o  = w_idx;
  assign bus.tbl_wdir_o = w_dir;
  assign bus.busy_o     = reset || (r_state == ST_INIT);

endmodule

// File: doc/bpd_upd_arb.md
BPD_UPD_ARB -- requirements
Module: bpd_upd_arb

Interface
REQ-001 Parameter IDX_W, default 12, sets the table index width (table has 2^IDX_W entries).
REQ-002 Parameter QDEPTH, default 4, sets the retire-update FIFO depth (power of two).
REQ-003 Parameter STARVE_LIM, default 8, sets the maximum cycles a queued update waits while reads win.
REQ-004 clock  in  1  single clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rd_req_i  in  1  fetch-stage prediction read request.
REQ-007 rd_idx_i  in  IDX_W  read index.
REQ-008 rd_gnt_o  out  1  read granted this cycle.
REQ-009 up_val_i  in  1  retire update valid.
REQ-010 up_idx_i  in  IDX_W  retire update index.
REQ-011 up_dir_i  in  1  retire resolved direction.
REQ-012 ch_val_i  in  1  choice-table update valid, unqueued.
REQ-013 ch_idx_i  in  IDX_W  choice update index.
REQ-014 ch_dir_i  in  1  choice update direction.
REQ-015 reinit_i  in  1  one-cycle pulse; restarts the table initialisation sweep.
REQ-016 tbl_en_o  out  1  table access enable.
REQ-017 tbl_we_o  out  1  table write enable.
REQ-018 tbl_idx_o  out  IDX_W  table index.
REQ-019 tbl_wdir_o  out  1  write direction.
REQ-020 tbl_init_o  out  1  write the weakly-taken init value; tbl_wdir_o is ignored.
REQ-021 busy_o  out  1  initialisation sweep in progress.
REQ-022 drop_o  out  1  pulse: an up or ch update was discarded this cycle.

Function
REQ-023 The block SHALL make at most one table access per cycle. All tbl_*, rd_gnt_o and drop_o outputs are combinational from the current state and inputs (zero-cycle grant).
REQ-024 The FSM SHALL have two states:
  - INIT: counter cnt steps 0..2^IDX_W-1, one write per cycle (tbl_en=1, tbl_we=1, tbl_init=1, tbl_idx=cnt). At cnt=2^IDX_W-1 it moves to RUN.
  - RUN: normal arbitration.
REQ-025 In INIT, rd_gnt_o SHALL be 0 and busy_o 1. Choice updates are dropped. Retire updates are pushed into the FIFO if it is not full, else dropped.
REQ-026 In RUN, grant priority SHALL be:
  1. FIFO head, if the FIFO is full or starve=STARVE_LIM;
  2. rd_req_i;
  3. FIFO head, if the FIFO is non-empty;
  4. ch_val_i.
REQ-027 A granted FIFO head SHALL drive tbl_we=1, tbl_idx=head idx, tbl_wdir=head dir, and pop the FIFO in the same cycle.
REQ-028 A ch update that is not granted SHALL be discarded with drop_o=1. It is never queued.
REQ-029 In RUN, a push on a full FIFO SHALL be accepted, because the pop of that cycle frees a slot. Push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-030 The starve counter SHALL:
  - increment each cycle the FIFO is non-empty and not popped;
  - clear on a pop or when the FIFO is empty;
  - saturate at STARVE_LIM.
REQ-031 reinit_i in RUN SHALL enter INIT with cnt=0 and keep FIFO contents. reinit_i during INIT SHALL restart cnt at 0.
REQ-032 The FIFO SHALL preserve order. Pointers wrap modulo QDEPTH, and occupancy is log2(QDEPTH)+1 bits wide.

Reset
REQ-033 While reset=1, tbl_en_o, tbl_we_o, rd_gnt_o, drop_o and tbl_init_o SHALL be 0, and busy_o SHALL be 1.
REQ-034 On the first edge after reset deasserts, the block SHALL be in INIT with cnt=0, FIFO empty and starve=0. Reset asserted mid-sweep or mid-drain discards all state.

Structure
REQ-035 The shared package bpd_pkg SHALL hold IDX_W, the init-counter encoding and the grant-source enum {GNT_NONE, GNT_INIT, GNT_RD, GNT_UP, GNT_CH}.
REQ-036 The update FIFO SHALL be the sub-module bpd_upd_fifo (push, pop, full, empty, head idx/dir).

Verification
REQ-037 Reset with IDX_W=4:
  - stimulus: deassert reset;
  - response: 16 init writes to idx 0..15, busy_o drops on cycle 17, rd_gnt_o=0 throughout.
REQ-038 Read versus queued update, in RUN, FIFO empty:
  - stimulus: rd_req=1 idx 0x2A0 and up_val idx 0x011 in the same cycle;
  - response: read granted; update written next cycle when rd_req=0.
REQ-039 Starvation:
  - stimulus: rd_req held 1 continuously, one update queued;
  - response: 8 reads granted, then the update is written on cycle 9 and rd_gnt_o=0 that cycle.
REQ-040 Full FIFO:
  - stimulus: fill to 4 entries, then up_val and rd_req together;
  - response: head pops, new entry is accepted, occupancy stays 4, read denied, drop_o=0.
REQ-041 Choice update lost to a read:
  - stimulus: ch_val=1 with rd_req=1;
  - response: drop_o=1, no write to ch_idx.
REQ-042 Reinit mid-drain:
  - stimulus: reinit_i with 2 entries queued;
  - response: full sweep, then both entries written in order after busy_o falls.
